// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for an ECC-protected memory: walks every word through the
// external SEC corrector and writes back any word the corrector changed.
//
// state | meaning
// IDLE  | parked, corrector disabled
// WAIT  | inter-sweep interval countdown (auto mode)
// READ  | issue read of addr once the host leaves the port free
// CAPT  | read data valid, register it into the corrector inputs
// CHK   | compare corrector output with the stored data
// WR    | write the corrected word back with its stored check bits
module ecc_scrub_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              host_busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [39:0]       mem_rdata,
  output logic [39:0]       mem_wdata,
  output logic [31:0]       cor_data,
  output logic [7:0]        cor_chk,
  output logic              cor_en,
  input  logic [31:0]       cor_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam int CNT_W = $clog2(INTERVAL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_CAPT, S_CHK, S_WR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_d;
  logic               capt;
  logic               adv;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    capt      = 1'b0;
    adv       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start || auto_en) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_WAIT: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
        end else if (!auto_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ: begin
        if (!host_busy) begin
          mem_re  = 1'b1;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        capt    = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        // host activity may have rewritten this word, so the captured copy is stale
        if (host_busy)                state_d = S_READ;
        else if (cor_out != cor_data) state_d = S_WR;
        else                          adv     = 1'b1;
      end
      S_WR: begin
        if (host_busy) begin
          state_d = S_READ;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = {cor_chk, cor_out};
          adv       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (addr_q == LAST_ADDR) begin
        done_d = 1'b1;
        addr_d = '0;
        if (auto_en) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(INTERVAL);
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_READ;
      end
    end

    if (rst) begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      done          <= 1'b0;
      cor_data      <= '0;
      cor_chk       <= '0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      if (capt) begin
        cor_chk  <= mem_rdata[39:32];
        cor_data <= mem_rdata[31:0];
      end
      if (mem_we) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        last_err_addr <= addr_q;
      end
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_WAIT);
  assign cor_en   = busy;

endmodule
